// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO of {pc, inst, tag} between fetch and decode.
// An empty queue presents a bubble to decode (pc = RESET_PC, inst = 0, tag = 0).
module if_id_queue #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INST_W    = 32,
  parameter int unsigned       TAG_W     = 4,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       AFULL_LVL = 3,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'hBFC00000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [ADDR_W-1:0]      if_pc,
  input  logic [INST_W-1:0]      if_inst,
  input  logic [TAG_W-1:0]       if_tag,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [TAG_W-1:0]       id_tag,
  input  logic                   flush,
  output logic                   if_afull,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             afull_q, afull_d;
  logic             push_s, pop_s;

  // if_ready looks only at the registered count and flush, never at id_ready.
  assign if_ready  = (count_q != FULL_CNT) && !flush;
  assign id_valid  = (count_q != CNT_ZERO);
  assign push_s    = if_valid && if_ready;
  assign pop_s     = id_valid && id_ready;
  assign occupancy = count_q;
  assign if_afull  = afull_q;

  // Head entry to decode, or the bubble when empty.
  always_comb begin
    id_pc   = RESET_PC;
    id_inst = {INST_W{1'b0}};
    id_tag  = {TAG_W{1'b0}};
    if (id_valid) begin
      id_pc   = pc_mem_q[rptr_q];
      id_inst = inst_mem_q[rptr_q];
      id_tag  = tag_mem_q[rptr_q];
    end else begin
      id_pc   = RESET_PC;
      id_inst = {INST_W{1'b0}};
      id_tag  = {TAG_W{1'b0}};
    end
  end

  // Pointer/count next state; flush overrides any push or pop in the same cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = PTR_ZERO;
      rptr_d  = PTR_ZERO;
      count_d = CNT_ZERO;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    afull_d = (count_d >= AFULL_CNT);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= PTR_ZERO;
      rptr_q  <= PTR_ZERO;
      count_q <= CNT_ZERO;
      afull_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      afull_q <= afull_d;
    end
  end

  // Entry storage is deliberately left uncleared; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[wptr_q]   <= if_pc;
      inst_mem_q[wptr_q] <= if_inst;
      tag_mem_q[wptr_q]  <= if_tag;
    end
  end

  if_id_queue_chk #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .wptr_q  (wptr_q),
    .rptr_q  (rptr_q),
    .count_q (count_q)
  );

endmodule

// if_id_queue_chk: simulation-only invariants on the queue's pointers and count.
module if_id_queue_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [PTR_W-1:0] wptr_q,
  input logic [PTR_W-1:0] rptr_q,
  input logic [CNT_W-1:0] count_q
);

  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));

  // Pointer difference wraps modulo DEPTH, matching count modulo DEPTH.
  a_ptr_consistent: assert property (@(posedge clk) disable iff (rst)
    PTR_W'(wptr_q - rptr_q) == count_q[PTR_W-1:0]);

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue (DEPTH = 4).
module tb_if_id_queue;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [3:0]  if_tag;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [3:0]  id_tag;
  logic        flush;
  logic        if_afull;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

  if_id_queue #(
    .ADDR_W    (32),
    .INST_W    (32),
    .TAG_W     (4),
    .DEPTH     (4),
    .AFULL_LVL (3),
    .RESET_PC  (32'hBFC00000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_tag    (if_tag),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_tag    (id_tag),
    .flush     (flush),
    .if_afull  (if_afull),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  // Apply inputs just after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] tag,
                       input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst_of(pc);
    if_tag   = tag;
    id_ready = rdy;
    flush    = fl;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bubble(input string t);
    check({t, "_valid"}, 64'(id_valid), 64'(1'b0));
    check({t, "_pc"},    64'(id_pc),    64'(RESET_PC));
    check({t, "_inst"},  64'(id_inst),  64'(32'h0));
    check({t, "_tag"},   64'(id_tag),   64'(4'h0));
  endtask

  task automatic expect_head(input string t, input logic [31:0] pc, input logic [3:0] tag);
    check({t, "_valid"}, 64'(id_valid), 64'(1'b1));
    check({t, "_pc"},    64'(id_pc),    64'(pc));
    check({t, "_inst"},  64'(id_inst),  64'(inst_of(pc)));
    check({t, "_tag"},   64'(id_tag),   64'(tag));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    expect_bubble("rst");
    check("rst_if_ready", 64'(if_ready), 64'(1'b1));
    check("rst_afull", 64'(if_afull), 64'(1'b0));
    check("rst_occ", 64'(occupancy), 64'(3'd0));

    // Fill with decode stalled
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 4'(k + 1), 1'b0, 1'b0);
      check("fill_if_ready", 64'(if_ready), 64'(1'b1));
      check("fill_occ", 64'(occupancy), 64'(k));
      check("fill_afull", 64'(if_afull), 64'(k >= 3));
      if (k == 0) check("fill_no_bypass", 64'(id_valid), 64'(1'b0));
      step();
    end
    drive(1'b1, 32'h110, 4'h5, 1'b0, 1'b0);
    check("full_if_ready", 64'(if_ready), 64'(1'b0));
    check("full_occ", 64'(occupancy), 64'(3'd4));
    check("full_afull", 64'(if_afull), 64'(1'b1));
    expect_head("full_head", 32'h100, 4'h1);
    step();
    check("full_hold_occ", 64'(occupancy), 64'(3'd4));

    // Drain
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      expect_head("drain", 32'h100 + 32'(4 * k), 4'(k + 1));
      check("drain_afull", 64'(if_afull), 64'((4 - k) >= 3));
      step();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    expect_bubble("drained");
    check("drained_occ", 64'(occupancy), 64'(3'd0));
    step();
    check("empty_pop_ignored", 64'(occupancy), 64'(3'd0));

    // Streaming: occupancy 1, id_pc one cycle behind if_pc
    for (int k = 0; k <= 20; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 4'h0, 1'b1, 1'b0);
      if (k == 0) begin
        check("stream_start_valid", 64'(id_valid), 64'(1'b0));
      end else begin
        check("stream_occ", 64'(occupancy), 64'(3'd1));
        check("stream_pc", 64'(id_pc), 64'(32'h200 + 32'(4 * (k - 1))));
      end
      step();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    check("stream_last_pc", 64'(id_pc), 64'(32'h250));
    step();
    check("stream_end_occ", 64'(occupancy), 64'(3'd0));

    // Wrap-around: entries 1..10 through the ring, occupancy up to 3
    for (int c = 0; c < 13; c++) begin
      drive(c < 10, 32'h600 + 32'(4 * (c + 1)), 4'(c + 1), c >= 3, 1'b0);
      check("wrap_occ", 64'(occupancy), 64'((c <= 3) ? c : ((c <= 10) ? 3 : 13 - c)));
      if (c >= 3) expect_head("wrap", 32'h600 + 32'(4 * (c - 2)), 4'(c - 2));
      step();
    end
    check("wrap_end_occ", 64'(occupancy), 64'(3'd0));

    // Flush beats a simultaneous push and pop
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h700 + 32'(4 * k), 4'h7, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h300, 4'h3, 1'b1, 1'b1);
    check("flush_if_ready", 64'(if_ready), 64'(1'b0));
    check("flush_pre_occ", 64'(occupancy), 64'(3'd3));
    step();
    drive(1'b1, 32'h720, 4'h9, 1'b0, 1'b0);
    expect_bubble("flushed");
    check("flushed_occ", 64'(occupancy), 64'(3'd0));
    check("flushed_afull", 64'(if_afull), 64'(1'b0));
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    expect_head("post_flush", 32'h720, 4'h9);
    check("post_flush_occ", 64'(occupancy), 64'(3'd1));
    step();

    // Full plus pop: push refused, held entry accepted next cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k), 4'(8 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h510, 4'hC, 1'b1, 1'b0);
    check("fullpop_if_ready", 64'(if_ready), 64'(1'b0));
    expect_head("fullpop_head", 32'h500, 4'h8);
    step();
    drive(1'b1, 32'h510, 4'hC, 1'b0, 1'b0);
    check("fullpop_occ", 64'(occupancy), 64'(3'd3));
    check("fullpop_retry_ready", 64'(if_ready), 64'(1'b1));
    step();
    check("fullpop_refill_occ", 64'(occupancy), 64'(3'd4));
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      expect_head("fullpop_drain", 32'h504 + 32'(4 * k), 4'(9 + k));
      step();
    end

    // Reset mid-operation with 2 entries queued
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h800 + 32'(4 * k), 4'h6, 1'b0, 1'b0);
      step();
    end
    check("pre_rst_occ", 64'(occupancy), 64'(3'd2));
    rst = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b1, 32'h400, 4'h4, 1'b0, 1'b0);
    expect_bubble("midrst");
    check("midrst_if_ready", 64'(if_ready), 64'(1'b1));
    check("midrst_afull", 64'(if_afull), 64'(1'b0));
    check("midrst_occ", 64'(occupancy), 64'(3'd0));
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    expect_head("post_rst", 32'h400, 4'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
